apb_slave_mem: RTL
==================

Name: apb_slave_mem

Overview:
- Word-addressed APB completer (slave) memory that sits directly downstream of the APB master. It consumes one PSELx bit plus the shared PADDR/PWRITE/PWDATA/PENABLE bus and returns PREADY/PRDATA/PSLVERR.
- Supports a programmable number of wait states per transfer.
- Flags misaligned and out-of-range accesses with PSLVERR.
- One instance is placed per PSELx bit.

Parameters:
- DEPTH, 16, number of 32-bit words; power of two, 2..1024.
- WAIT_W, 4, width of the wait-state count input.

Ports:
- PCLK     in   1       clock; all logic on rising edge.
- PRESETn  in   1       asynchronous active-low reset.
- PSEL     in   1       select; this slave's bit of the master's PSELx.
- PENABLE  in   1       access-phase indicator.
- PADDR    in   32      byte address; [31:30] already decoded upstream and ignored here.
- PWRITE   in   1       1 = write, 0 = read.
- PWDATA   in   32      write data.
- PSTRB    in   4       byte strobes; present only with APB_STRB_EN.
- WAIT_CYC in   WAIT_W  wait states for the next transfer; sampled in the setup cycle.
- PREADY   out  1       transfer-complete indicator.
- PRDATA   out  32      read data.
- PSLVERR  out  1       error response.

Behaviour:
- Reset (async, PRESETn=0): PREADY=0, PRDATA=0, PSLVERR=0, FSM=IDLE, wait counter=0, all memory words=0. Reset mid-transfer aborts the transfer with no write.
- All outputs are registered.
- Setup cycle = PSEL=1 and PENABLE=0 while FSM=IDLE. At its closing edge the block latches PADDR, PWRITE, PWDATA (and PSTRB), and loads cnt=WAIT_CYC.
- FSM IDLE:
  - On a setup cycle, go to READY if WAIT_CYC==0, else go to WAIT.
  - PREADY <= (WAIT_CYC==0).
- FSM WAIT:
  - PREADY=0; cnt decrements each cycle.
  - When cnt==1 at a clock edge, go to READY with PREADY<=1.
  - If PSEL drops in WAIT (master abort), go to IDLE: PREADY=0, no write, PSLVERR=0.
- FSM READY:
  - PREADY=1 for exactly one cycle, which is the completing access cycle.
  - Always returns to IDLE with PREADY<=0, PRDATA<=0, PSLVERR<=0.
  - A back-to-back setup arrives in the cycle after READY and is accepted normally.
- Latency: with N=WAIT_CYC, PREADY is high in the (N+1)th access cycle; the first access cycle is the cycle after setup.
- Error check on the latched address:
  - misaligned: PADDR[1:0]!=0;
  - out of range: word index PADDR[29:2] >= DEPTH.
  - On error: PSLVERR=1 together with PREADY=1 in the READY cycle, PRDATA=0, memory unchanged.
  - Wait states are honoured on error too.
- Write (no error): memory[PADDR[log2(DEPTH)+1:2]] updated at the closing edge of the READY cycle. PRDATA stays 0.
- Read (no error): PRDATA = memory word, registered so it is valid exactly in the READY cycle; 0 in all other cycles.
- Read immediately after a write to the same word returns the new value.
- PENABLE=1 seen in IDLE without a preceding setup: ignored, no response.
- WAIT_CYC changes outside the setup cycle have no effect on a transfer in progress.

Optional Feature:
- Macro: APB_STRB_EN.
- Defined:
  - PSTRB port exists and is latched at setup.
  - A write updates only the byte lanes with PSTRB[i]=1; PSTRB=0000 on a write leaves memory unchanged and is not an error.
  - PSTRB is ignored on reads.
- Undefined: no PSTRB port; every write updates all 4 bytes.

Test Plan:
1. Reset, then write 0xDEADBEEF to PADDR=0x08 with WAIT_CYC=0, then read 0x08 -> PREADY in the first access cycle for both transfers; read PRDATA=0xDEADBEEF; PSLVERR=0.
2. WAIT_CYC=3, read 0x04 after writing 0x12345678 -> PREADY low for 3 access cycles, high in the 4th with PRDATA=0x12345678; PRDATA=0 in all wait cycles.
3. Write to PADDR=0x02 (misaligned), then to PADDR=DEPTH*4=0x40 (out of range) -> PSLVERR=1 with PREADY=1 for each; a following read of word 0 returns its prior value unchanged.
4. PRESETn pulsed low during a WAIT_CYC=5 write -> outputs 0 immediately; a read of that word afterward returns 0; the next transfer completes normally.
5. Back-to-back write 0xA5A5A5A5 to 0x0C then read 0x0C with no idle cycle between (WAIT_CYC=1) -> second setup accepted; read PRDATA=0xA5A5A5A5.
6. APB_STRB_EN: write 0xFFFFFFFF, then write 0x11223344 with PSTRB=0101 to 0x10 -> read returns 0xFF22FF44.

Source files
------------

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: word-addressed APB completer memory with programmable wait states
// and PSLVERR on misaligned/out-of-range access. Optional byte strobes: APB_STRB_EN.
`default_nettype none

module apb_slave_mem #(
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [31:0]       PADDR,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
`ifdef APB_STRB_EN
  input  logic [3:0]        PSTRB,
`endif
  input  logic [WAIT_W-1:0] WAIT_CYC,
  output logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [29:0]       addr_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [WAIT_W-1:0] cnt;
  logic [31:0]       mem [DEPTH];

  logic              setup;
  logic [29:0]       cur_addr;
  logic              cur_write;
  logic [AW-1:0]     cur_idx;
  logic              cur_err;
  logic [3:0]        strb_in;
  logic              unused_bits;

`ifdef APB_STRB_EN
  assign strb_in = PSTRB;
`else
  assign strb_in = 4'hF;
`endif

  assign unused_bits = ^PADDR[31:30];

  assign setup = (state == ST_IDLE) && PSEL && !PENABLE;

  // In IDLE the response for a zero-wait transfer is built straight from the bus;
  // otherwise from the values latched at setup.
  assign cur_addr  = (state == ST_IDLE) ? PADDR[29:0] : addr_q;
  assign cur_write = (state == ST_IDLE) ? PWRITE      : wr_q;
  assign cur_idx   = cur_addr[AW+1:2];
  assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[29:2] >= 28'(DEPTH));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (setup) state_nxt = (WAIT_CYC == '0) ? ST_READY : ST_WAIT;
      end
      ST_WAIT: begin
        if (!PSEL)                       state_nxt = ST_IDLE;
        else if (cnt == WAIT_W'(1))      state_nxt = ST_READY;
      end
      ST_READY: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt     <= '0;
    end else if (setup) begin
      addr_q  <= PADDR[29:0];
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= strb_in;
      cnt     <= WAIT_CYC;
    end else if (state == ST_WAIT) begin
      cnt     <= cnt - WAIT_W'(1);
    end
  end

  // Outputs are zero except in the single READY cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      if (state_nxt == ST_READY) begin
        PREADY  <= 1'b1;
        PSLVERR <= cur_err;
        if (!cur_err && !cur_write) PRDATA <= mem[cur_idx];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_READY && wr_q && !cur_err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[cur_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire
